// File: rtl/watchdog_kicker.sv
// watchdog_kicker: 68k bus-initiator model that periodically writes a byte to
// $300001 to service the system watchdog. It requests the bus, runs a full
// write cycle (address setup, strobe, hold), then releases the bus.
// It also reports completed kicks, grant timeouts and observed system resets.
// Optional build macro WATCHDOG_KICKER_RSTCNT_EN enables counting of nRESET
// falling edges on RESET_COUNT. When the macro is undefined, RESET_COUNT
// reads 0.
module watchdog_kicker #(
  parameter int INTERVAL    = 6,  // WDCLK ticks between kicks, 2..7
  parameter int STROBE_LEN  = 1,  // cycles nLDS is held low, 1..3
  parameter int GNT_TIMEOUT = 4   // cycles to wait for BUS_GNT
) (
  input  logic       WDCLK,
  input  logic       WDRESET,
  input  logic       ENABLE,
  input  logic       FORCE_KICK,
  input  logic       BUS_GNT,
  input  logic       nRESET,
  output logic       BUS_REQ,
  output logic       nLDS,
  output logic       RW,
  output logic       A23I,
  output logic       A22I,
  output logic [4:0] M68K_ADDR_U,
  output logic       KICK_DONE,
  output logic [7:0] KICK_COUNT,
  output logic       MISS,
  output logic [3:0] RESET_COUNT
);

  localparam int              WAIT_W    = (GNT_TIMEOUT > 1) ? $clog2(GNT_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(GNT_TIMEOUT - 1);
  localparam logic [1:0]      STRB_LAST = 2'(STROBE_LEN - 1);
  localparam logic [2:0]      DUE_CNT   = 3'(INTERVAL - 1);
  // A23, A22 and A21..A17 for the watchdog byte address $300001.
  localparam logic [6:0]      KICK_ADDR = 7'b00_11000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_ADDR,
    ST_STROBE,
    ST_REL
  } state_t;

  state_t            r_state;
  logic [2:0]        r_int_cnt;
  logic              r_pending;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [1:0]        r_strb_cnt;
  logic              r_bus_req;
  logic              r_nlds;
  logic              r_rw;
  logic              r_a23;
  logic              r_a22;
  logic [4:0]        r_addr_u;
  logic              r_kick_done;
  logic [7:0]        r_kick_count;
  logic              r_miss;

  logic w_due;
  logic w_abort;

  assign w_due = (r_int_cnt == DUE_CNT);

  // Leaving the bus mid-cycle: system reset in any active state, or grant
  // withdrawn once we own the bus. REQ has its own timeout for a missing grant.
  assign w_abort = (r_state != ST_IDLE) &&
                   (!nRESET || ((r_state != ST_REQ) && !BUS_GNT));

  // Kick sequencer: state, counters and all registered bus/status outputs.
  always_ff @(posedge WDCLK or posedge WDRESET) begin
    if (WDRESET) begin
      r_state      <= ST_IDLE;
      r_int_cnt    <= '0;
      r_pending    <= 1'b0;
      r_wait_cnt   <= '0;
      r_strb_cnt   <= '0;
      r_bus_req    <= 1'b0;
      r_nlds       <= 1'b1;
      r_rw         <= 1'b1;
      r_a23        <= 1'b0;
      r_a22        <= 1'b0;
      r_addr_u     <= '0;
      r_kick_done  <= 1'b0;
      r_kick_count <= '0;
      r_miss       <= 1'b0;
    end else begin
      r_kick_done <= 1'b0;
      r_miss      <= 1'b0;
      // A force request is remembered in any state. Entry to REQ below clears
      // it, and that clear wins, so one kick absorbs both triggers.
      if (FORCE_KICK) begin
        r_pending <= 1'b1;
      end
      if (w_abort) begin
        r_state                  <= ST_IDLE;
        r_bus_req                <= 1'b0;
        r_nlds                   <= 1'b1;
        r_rw                     <= 1'b1;
        {r_a23, r_a22, r_addr_u} <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (!nRESET) begin
              r_int_cnt <= '0;
            end else if (w_due || r_pending) begin
              r_state    <= ST_REQ;
              r_bus_req  <= 1'b1;
              r_int_cnt  <= '0;
              r_pending  <= 1'b0;
              r_wait_cnt <= '0;
            end else if (ENABLE) begin
              r_int_cnt <= r_int_cnt + 3'd1;
            end
          end
          ST_REQ: begin
            if (BUS_GNT) begin
              r_state                  <= ST_ADDR;
              r_rw                     <= 1'b0;
              {r_a23, r_a22, r_addr_u} <= KICK_ADDR;
            end else if (r_wait_cnt == WAIT_LAST) begin
              r_state   <= ST_IDLE;
              r_bus_req <= 1'b0;
              r_miss    <= 1'b1;
            end else begin
              r_wait_cnt <= r_wait_cnt + 1'b1;
            end
          end
          ST_ADDR: begin
            r_state    <= ST_STROBE;
            r_nlds     <= 1'b0;
            r_strb_cnt <= '0;
          end
          ST_STROBE: begin
            if (r_strb_cnt == STRB_LAST) begin
              // Strobe and RW release together. The address stays for hold.
              r_state     <= ST_REL;
              r_nlds      <= 1'b1;
              r_rw        <= 1'b1;
              r_kick_done <= 1'b1;
              if (r_kick_count != 8'hFF) begin
                r_kick_count <= r_kick_count + 8'd1;
              end
            end else begin
              r_strb_cnt <= r_strb_cnt + 2'd1;
            end
          end
          ST_REL: begin
            r_state                  <= ST_IDLE;
            r_bus_req                <= 1'b0;
            {r_a23, r_a22, r_addr_u} <= '0;
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign BUS_REQ     = r_bus_req;
  assign nLDS        = r_nlds;
  assign RW          = r_rw;
  assign A23I        = r_a23;
  assign A22I        = r_a22;
  assign M68K_ADDR_U = r_addr_u;
  assign KICK_DONE   = r_kick_done;
  assign KICK_COUNT  = r_kick_count;
  assign MISS        = r_miss;

`ifdef WATCHDOG_KICKER_RSTCNT_EN
  logic       r_nreset_q;
  logic [3:0] r_reset_count;

  // Count 1->0 transitions of the observed system reset, saturating at 15.
  // The history flop starts low so that reset release alone never counts.
  always_ff @(posedge WDCLK or posedge WDRESET) begin
    if (WDRESET) begin
      r_nreset_q    <= 1'b0;
      r_reset_count <= '0;
    end else begin
      r_nreset_q <= nRESET;
      if (r_nreset_q && !nRESET && (r_reset_count != 4'hF)) begin
        r_reset_count <= r_reset_count + 4'd1;
      end
    end
  end

  assign RESET_COUNT = r_reset_count;
`else
  assign RESET_COUNT = 4'd0;
`endif

endmodule

// File: tb/tb_watchdog_kicker.sv
// tb_watchdog_kicker: scoreboard bench for watchdog_kicker. Expected
// KICK_COUNT values are queued when a kick (or a grant timeout) is provoked.
// A negedge monitor pops them on KICK_DONE / MISS and checks the bus.
module tb_watchdog_kicker;

`ifdef WATCHDOG_KICKER_RSTCNT_EN
  localparam int RC_ON = 1;
`else
  localparam int RC_ON = 0;
`endif

  logic       WDCLK = 1'b0;
  logic       WDRESET;
  logic       ENABLE;
  logic       FORCE_KICK;
  logic       BUS_GNT;
  logic       nRESET;
  logic       BUS_REQ;
  logic       nLDS;
  logic       RW;
  logic       A23I;
  logic       A22I;
  logic [4:0] M68K_ADDR_U;
  logic       KICK_DONE;
  logic [7:0] KICK_COUNT;
  logic       MISS;
  logic [3:0] RESET_COUNT;

  int n_compared = 0;
  int n_mismatch = 0;
  int kick_q[$];
  int miss_q[$];
  int strobe_run  = 0;
  int last_strobe = 0;
  int mon_exp;
  logic prev_nlds = 1'b1;

  always #5 WDCLK = ~WDCLK;

  watchdog_kicker dut (
    .WDCLK       (WDCLK),
    .WDRESET     (WDRESET),
    .ENABLE      (ENABLE),
    .FORCE_KICK  (FORCE_KICK),
    .BUS_GNT     (BUS_GNT),
    .nRESET      (nRESET),
    .BUS_REQ     (BUS_REQ),
    .nLDS        (nLDS),
    .RW          (RW),
    .A23I        (A23I),
    .A22I        (A22I),
    .M68K_ADDR_U (M68K_ADDR_U),
    .KICK_DONE   (KICK_DONE),
    .KICK_COUNT  (KICK_COUNT),
    .MISS        (MISS),
    .RESET_COUNT (RESET_COUNT)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatch++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Count negedges until BUS_REQ is seen high, bounded by budget.
  task automatic wait_req(input int budget, output int n);
    n = 0;
    do begin
      @(negedge WDCLK);
      n++;
    end while (!BUS_REQ && n < budget);
    check("req_seen", BUS_REQ, 1'b1);
  endtask

  task automatic wait_strobe(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge WDCLK);
      n++;
    end while (nLDS && n < budget);
    check("strobe_seen", nLDS, 1'b0);
  endtask

  task automatic pulse_force();
    FORCE_KICK = 1'b1;
    @(negedge WDCLK);
    FORCE_KICK = 1'b0;
  endtask

  // Monitor: bus shape during strobe, and scoreboard pops on KICK_DONE / MISS.
  always @(negedge WDCLK) begin
    if (WDRESET) begin
      prev_nlds  = 1'b1;
      strobe_run = 0;
    end else begin
      if (!nLDS) begin
        check("strobe_addr", {A23I, A22I, M68K_ADDR_U}, 7'b0011000);
        check("strobe_rw", RW, 1'b0);
        strobe_run++;
      end else if (!prev_nlds) begin
        last_strobe = strobe_run;
        strobe_run  = 0;
      end
      prev_nlds = nLDS;
      if (KICK_DONE) begin
        check("kick_expected", kick_q.size() > 0, 1'b1);
        if (kick_q.size() > 0) begin
          mon_exp = kick_q.pop_front();
          check("kick_count", KICK_COUNT, mon_exp);
          $display("kick done: count=%0d expected=%0d", KICK_COUNT, mon_exp);
        end
        check("kick_strobe_len", last_strobe, 1);
        check("rel_bus", {BUS_REQ, nLDS, RW, A23I, A22I, M68K_ADDR_U}, 10'b111_0011000);
      end
      if (MISS) begin
        check("miss_expected", miss_q.size() > 0, 1'b1);
        if (miss_q.size() > 0) begin
          mon_exp = miss_q.pop_front();
          check("miss_count", KICK_COUNT, mon_exp);
          $display("grant miss: count=%0d expected=%0d", KICK_COUNT, mon_exp);
        end
        check("miss_bus", {BUS_REQ, nLDS, RW}, 3'b011);
      end
    end
  end

  initial begin
    int n;
    int highs;
    int cyc;
    WDRESET    = 1'b1;
    ENABLE     = 1'b0;
    FORCE_KICK = 1'b0;
    BUS_GNT    = 1'b1;
    nRESET     = 1'b1;
    repeat (3) @(negedge WDCLK);
    check("reset_bus", {BUS_REQ, nLDS, RW, A23I, A22I, M68K_ADDR_U, KICK_DONE, MISS},
          12'b011_00_00000_00);
    check("reset_kick_count", KICK_COUNT, 8'd0);
    check("reset_reset_count", RESET_COUNT, 4'd0);
    WDRESET = 1'b0;
    @(negedge WDCLK);

    // Periodic kicking with the grant tied high.
    kick_q.push_back(1);
    kick_q.push_back(2);
    ENABLE = 1'b1;
    wait_req(50, n);
    check("first_req_latency", n, 6);
    n = 0;
    do begin @(negedge WDCLK); n++; end while (BUS_REQ && n < 40);
    do begin @(negedge WDCLK); n++; end while (!BUS_REQ && n < 40);
    check("kick_period", n, 10);
    @(negedge WDCLK);
    check("addr_setup", {BUS_REQ, nLDS, RW, A23I, A22I, M68K_ADDR_U}, 10'b110_0011000);
    ENABLE = 1'b0;  // dropped mid-kick: this kick still completes
    repeat (40) @(negedge WDCLK);
    check("count_after_periodic", KICK_COUNT, 8'd2);

    // Forced kick with periodic kicking disabled.
    kick_q.push_back(3);
    pulse_force();
    wait_req(50, n);
    check("force_latency", n + 1, 2);
    repeat (40) @(negedge WDCLK);
    check("count_after_force", KICK_COUNT, 8'd3);

    // Grant never arrives: request held GNT_TIMEOUT cycles, then MISS.
    BUS_GNT = 1'b0;
    miss_q.push_back(3);
    pulse_force();
    wait_req(50, n);
    highs = 0;
    while (BUS_REQ && highs < 20) begin
      highs++;
      @(negedge WDCLK);
    end
    check("gnt_timeout_req_cycles", highs, 4);
    @(negedge WDCLK);
    BUS_GNT = 1'b1;
    repeat (20) @(negedge WDCLK);
    check("count_after_miss", KICK_COUNT, 8'd3);
    check("miss_queue_drained", miss_q.size(), 0);

    // System reset during strobe aborts the kick and holds the interval counter.
    pulse_force();
    wait_strobe(50);
    nRESET = 1'b0;
    ENABLE = 1'b1;
    @(negedge WDCLK);
    check("abort_bus", {BUS_REQ, nLDS, RW, A23I, A22I, M68K_ADDR_U, KICK_DONE},
          11'b011_0000000_0);
    highs = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge WDCLK);
      if (BUS_REQ) highs++;
    end
    check("held_in_nreset", highs, 0);
    check("count_after_abort", KICK_COUNT, 8'd3);
    check("reset_count_one", RESET_COUNT, RC_ON * 1);

    // Release system reset and run into saturation of KICK_COUNT.
    for (int k = 4; k < 264; k++) begin
      kick_q.push_back((k > 255) ? 255 : k);
    end
    nRESET = 1'b1;
    wait_req(50, n);
    check("post_nreset_latency", n, 6);
    cyc = 0;
    while (kick_q.size() > 0 && cyc < 3000) begin
      @(negedge WDCLK);
      cyc++;
    end
    check("sat_queue_drained", kick_q.size(), 0);
    ENABLE = 1'b0;
    repeat (20) @(negedge WDCLK);
    check("saturated_count", KICK_COUNT, 8'd255);

    // Three further nRESET pulses while idle.
    for (int i = 0; i < 3; i++) begin
      nRESET = 1'b0;
      repeat (2) @(negedge WDCLK);
      nRESET = 1'b1;
      repeat (2) @(negedge WDCLK);
    end
    check("reset_count_pulses", RESET_COUNT, RC_ON * 4);
    check("count_after_pulses", KICK_COUNT, 8'd255);

    // Asynchronous WDRESET in the middle of a strobe.
    pulse_force();
    wait_strobe(50);
    WDRESET = 1'b1;
    #1;
    check("async_reset_bus", {BUS_REQ, nLDS, RW, A23I, A22I, M68K_ADDR_U, KICK_DONE, MISS},
          12'b011_00_00000_00);
    check("async_reset_counts", {KICK_COUNT, RESET_COUNT}, 12'h000);
    repeat (2) @(negedge WDCLK);
    check("kick_queue_empty", kick_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
